// File: rtl/fused_pkg.sv
// rtl/fused_pkg.sv - shared states, segment tags and bank-count constants for the fused-layer loader
package fused_pkg;

    localparam int N_W1_LOG2 = 4;
    localparam int N_W2_LOG2 = 2;

    typedef enum logic [2:0] {IDLE, RD_IFM, RD_W1, RD_W2, DRAIN, FIN} load_state_t;
    typedef enum logic [1:0] {SEG_IFM, SEG_W1, SEG_W2} seg_t;

    function automatic load_state_t seg_state(input seg_t s);
        case (s)
            SEG_W1:  return RD_W1;
            SEG_W2:  return RD_W2;
            default: return RD_IFM;
        endcase
    endfunction

    // Next read state after a segment's last issue; empty segments are skipped outright.
    function automatic load_state_t after_seg(input seg_t s, input logic w1_nz, input logic w2_nz);
        if (s == SEG_IFM && w1_nz)
            return RD_W1;
        if (s != SEG_W2 && w2_nz)
            return RD_W2;
        return DRAIN;
    endfunction

endpackage

// File: rtl/fused_bank_decode.sv
// rtl/fused_bank_decode.sv - maps a {segment, word index} tag to one local write enable and bank-local address
module fused_bank_decode
    import fused_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int N_W1   = 16,
    parameter int N_W2   = 4
) (
    input  logic              valid,
    input  logic [1:0]        seg,
    input  logic [ADDR_W-1:0] index,
    output logic              we_IFM,
    output logic [N_W1-1:0]   we_W1,
    output logic [N_W2-1:0]   we_W2,
    output logic [ADDR_W-1:0] local_addr
);

    localparam int L1 = $clog2(N_W1);
    localparam int L2 = $clog2(N_W2);

    always_comb begin
        we_IFM     = 1'b0;
        we_W1      = '0;
        we_W2      = '0;
        local_addr = index;
        if (valid) begin
            case (seg_t'(seg))
                SEG_IFM: we_IFM = 1'b1;
                SEG_W1: begin
                    we_W1      = N_W1'(1) << index[L1-1:0];
                    local_addr = index >> L1;
                end
                SEG_W2: begin
                    we_W2      = N_W2'(1) << index[L2-1:0];
                    local_addr = index >> L2;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fused_bram_loader.sv
// rtl/fused_bram_loader.sv - streams IFM, W1 and W2 segments from global BRAM into local banks; FUSED_LOADER_PERF_EN adds perf counters
module fused_bram_loader
    import fused_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 32,
    parameter int N_W1   = 1 << N_W1_LOG2,
    parameter int N_W2   = 1 << N_W2_LOG2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              hold,
    input  logic [ADDR_W-1:0] base_addr_IFM,
    input  logic [ADDR_W-1:0] size_IFM,
    input  logic [ADDR_W-1:0] base_addr_Weight_layer_1,
    input  logic [ADDR_W-1:0] size_Weight_layer_1,
    input  logic [ADDR_W-1:0] base_addr_Weight_layer_2,
    input  logic [ADDR_W-1:0] size_Weight_layer_2,
    output logic [ADDR_W-1:0] rd_addr_global,
    input  logic [DATA_W-1:0] rd_data_global,
    output logic [DATA_W-1:0] wr_data_local,
    output logic [ADDR_W-1:0] wr_addr_local,
    output logic              we_IFM,
    output logic [N_W1-1:0]   we_W1,
    output logic [N_W2-1:0]   we_W2,
    output logic              busy,
    output logic              done
`ifdef FUSED_LOADER_PERF_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_stall
`endif
);

    load_state_t       state;
    logic [ADDR_W-1:0] base_ifm_r, base_w1_r, base_w2_r;
    logic [ADDR_W-1:0] size_ifm_r, size_w1_r, size_w2_r;
    logic [ADDR_W-1:0] idx;
    logic              tag_valid;
    seg_t              tag_seg;
    logic [ADDR_W-1:0] tag_idx;

    logic              idle;
    logic [ADDR_W-1:0] eff_base_ifm, eff_base_w1, eff_base_w2;
    logic [ADDR_W-1:0] eff_size_ifm, eff_size_w1, eff_size_w2;
    logic              can_issue;
    seg_t              cur_seg;
    logic [ADDR_W-1:0] cur_base, cur_size, cur_idx;

    logic              dec_ifm;
    logic [N_W1-1:0]   dec_w1;
    logic [N_W2-1:0]   dec_w2;
    logic [ADDR_W-1:0] dec_addr;

    assign wr_data_local = rd_data_global;

    // In IDLE the first read issues on the accepting edge, so it must see the raw inputs.
    always_comb begin
        idle         = (state == IDLE);
        eff_base_ifm = idle ? base_addr_IFM            : base_ifm_r;
        eff_base_w1  = idle ? base_addr_Weight_layer_1 : base_w1_r;
        eff_base_w2  = idle ? base_addr_Weight_layer_2 : base_w2_r;
        eff_size_ifm = idle ? size_IFM                 : size_ifm_r;
        eff_size_w1  = idle ? size_Weight_layer_1      : size_w1_r;
        eff_size_w2  = idle ? size_Weight_layer_2      : size_w2_r;

        can_issue = 1'b0;
        cur_seg   = SEG_IFM;
        cur_base  = eff_base_ifm;
        cur_size  = eff_size_ifm;
        cur_idx   = idx;
        case (state)
            IDLE: begin
                cur_idx = '0;
                if (start) begin
                    if (eff_size_ifm != '0) begin
                        can_issue = 1'b1;
                    end else if (eff_size_w1 != '0) begin
                        can_issue = 1'b1;
                        cur_seg   = SEG_W1;
                        cur_base  = eff_base_w1;
                        cur_size  = eff_size_w1;
                    end else if (eff_size_w2 != '0) begin
                        can_issue = 1'b1;
                        cur_seg   = SEG_W2;
                        cur_base  = eff_base_w2;
                        cur_size  = eff_size_w2;
                    end
                end
            end
            RD_IFM: can_issue = 1'b1;
            RD_W1: begin
                can_issue = 1'b1;
                cur_seg   = SEG_W1;
                cur_base  = eff_base_w1;
                cur_size  = eff_size_w1;
            end
            RD_W2: begin
                can_issue = 1'b1;
                cur_seg   = SEG_W2;
                cur_base  = eff_base_w2;
                cur_size  = eff_size_w2;
            end
            default: ;
        endcase
    end

    fused_bank_decode #(
        .ADDR_W (ADDR_W),
        .N_W1   (N_W1),
        .N_W2   (N_W2)
    ) u_decode (
        .valid      (tag_valid),
        .seg        (tag_seg),
        .index      (tag_idx),
        .we_IFM     (dec_ifm),
        .we_W1      (dec_w1),
        .we_W2      (dec_w2),
        .local_addr (dec_addr)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            rd_addr_global <= '0;
            wr_addr_local  <= '0;
            we_IFM         <= 1'b0;
            we_W1          <= '0;
            we_W2          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            base_ifm_r     <= '0;
            base_w1_r      <= '0;
            base_w2_r      <= '0;
            size_ifm_r     <= '0;
            size_w1_r      <= '0;
            size_w2_r      <= '0;
            idx            <= '0;
            tag_valid      <= 1'b0;
            tag_seg        <= SEG_IFM;
            tag_idx        <= '0;
        end else begin
            done      <= 1'b0;
            tag_valid <= 1'b0;
            we_IFM    <= dec_ifm;
            we_W1     <= dec_w1;
            we_W2     <= dec_w2;
            if (tag_valid)
                wr_addr_local <= dec_addr;

            case (state)
                IDLE: if (start) begin
                    busy       <= 1'b1;
                    base_ifm_r <= base_addr_IFM;
                    base_w1_r  <= base_addr_Weight_layer_1;
                    base_w2_r  <= base_addr_Weight_layer_2;
                    size_ifm_r <= size_IFM;
                    size_w1_r  <= size_Weight_layer_1;
                    size_w2_r  <= size_Weight_layer_2;
                    idx        <= '0;
                    state      <= FIN;
                end
                DRAIN: state <= FIN;
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: ;
            endcase

            // Issue path overrides the state chosen above whenever a segment has words left.
            if (can_issue) begin
                if (hold) begin
                    state <= seg_state(cur_seg);
                    idx   <= cur_idx;
                end else begin
                    rd_addr_global <= cur_base + cur_idx;
                    tag_valid      <= 1'b1;
                    tag_seg        <= cur_seg;
                    tag_idx        <= cur_idx;
                    if (cur_idx == cur_size - ADDR_W'(1)) begin
                        state <= after_seg(cur_seg, eff_size_w1 != '0, eff_size_w2 != '0);
                        idx   <= '0;
                    end else begin
                        state <= seg_state(cur_seg);
                        idx   <= cur_idx + ADDR_W'(1);
                    end
                end
            end
        end
    end

`ifdef FUSED_LOADER_PERF_EN
    // The accepting cycle counts as the first busy cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else if (idle && start) begin
            perf_cycles <= 32'd1;
            perf_stall  <= {31'd0, hold};
        end else if (busy) begin
            perf_cycles <= perf_cycles + 32'd1;
            if (hold)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`else
    // Counters are not built without the perf option.
`endif

endmodule

// File: tb/tb_fused_bram_loader.sv
// tb/tb_fused_bram_loader.sv - directed self-checking bench for fused_bram_loader
module tb_fused_bram_loader;

    logic         clk = 1'b0;
    logic         reset_n, start, hold;
    logic [31:0]  base_addr_IFM, size_IFM;
    logic [31:0]  base_addr_Weight_layer_1, size_Weight_layer_1;
    logic [31:0]  base_addr_Weight_layer_2, size_Weight_layer_2;
    logic [31:0]  rd_addr_global, wr_addr_local;
    logic [127:0] rd_data_global = '0;
    logic [127:0] wr_data_local;
    logic         we_IFM;
    logic [15:0]  we_W1;
    logic [3:0]   we_W2;
    logic         busy, done;
`ifdef FUSED_LOADER_PERF_EN
    logic [31:0]  perf_cycles, perf_stall;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0]  s_ra [0:63];
    logic [31:0]  s_wa [0:63];
    logic [127:0] s_wd [0:63];
    logic         s_wi [0:63];
    logic [15:0]  s_w1 [0:63];
    logic [3:0]   s_w2 [0:63];
    logic         s_bs [0:63];
    logic         s_dn [0:63];

    always #5 clk = ~clk;

    always @(posedge clk) rd_data_global <= {64'hCAFE_F00D_1234_5678, 32'h0, rd_addr_global};

    fused_bram_loader dut (
        .clk                      (clk),
        .reset_n                  (reset_n),
        .start                    (start),
        .hold                     (hold),
        .base_addr_IFM            (base_addr_IFM),
        .size_IFM                 (size_IFM),
        .base_addr_Weight_layer_1 (base_addr_Weight_layer_1),
        .size_Weight_layer_1      (size_Weight_layer_1),
        .base_addr_Weight_layer_2 (base_addr_Weight_layer_2),
        .size_Weight_layer_2      (size_Weight_layer_2),
        .rd_addr_global           (rd_addr_global),
        .rd_data_global           (rd_data_global),
        .wr_data_local            (wr_data_local),
        .wr_addr_local            (wr_addr_local),
        .we_IFM                   (we_IFM),
        .we_W1                    (we_W1),
        .we_W2                    (we_W2),
        .busy                     (busy),
        .done                     (done)
`ifdef FUSED_LOADER_PERF_EN
        ,
        .perf_cycles              (perf_cycles),
        .perf_stall               (perf_stall)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] gword(input logic [31:0] a);
        return {64'hCAFE_F00D_1234_5678, 32'h0, a};
    endfunction

    function automatic int writes(input int n);
        int s = 0;
        for (int k = 1; k <= n; k++)
            s += int'(s_wi[k]) + $countones(s_w1[k]) + $countones(s_w2[k]);
        return s;
    endfunction

    function automatic int multi(input int n);
        int s = 0;
        for (int k = 1; k <= n; k++)
            if (int'(s_wi[k]) + $countones(s_w1[k]) + $countones(s_w2[k]) > 1) s++;
        return s;
    endfunction

    function automatic int done_at(input int n);
        for (int k = 1; k <= n; k++)
            if (s_dn[k] === 1'b1) return k;
        return -1;
    endfunction

    function automatic logic [15:0] w1_or(input int n);
        logic [15:0] a = '0;
        for (int k = 1; k <= n; k++) a |= s_w1[k];
        return a;
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        hold    = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic set_seg(input logic [31:0] b0, s0, b1, s1, b2, s2);
        base_addr_IFM            = b0;
        size_IFM                 = s0;
        base_addr_Weight_layer_1 = b1;
        size_Weight_layer_1      = s1;
        base_addr_Weight_layer_2 = b2;
        size_Weight_layer_2      = s2;
    endtask

    // Cycle 0 carries start; cycle k is sampled at the falling edge after the k-th rising edge.
    task automatic run(input int ncyc, input int h_lo, input int h_hi, input int restart);
        @(negedge clk);
        start = 1'b1;
        hold  = (0 >= h_lo && 0 <= h_hi);
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            start   = (k == restart);
            s_ra[k] = rd_addr_global;
            s_wa[k] = wr_addr_local;
            s_wd[k] = wr_data_local;
            s_wi[k] = we_IFM;
            s_w1[k] = we_W1;
            s_w2[k] = we_W2;
            s_bs[k] = busy;
            s_dn[k] = done;
            hold    = (k >= h_lo && k <= h_hi);
        end
        start = 1'b0;
        hold  = 1'b0;
    endtask

    initial begin
        set_seg(32'h100, 32'd4, 32'h200, 32'd32, 32'h300, 32'd8);
        reset_n = 1'b0;
        start   = 1'b0;
        hold    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rd_addr", rd_addr_global, 32'h0);
        chk("rst_wr_addr", wr_addr_local, 32'h0);
        chk("rst_we", {we_IFM, we_W1, we_W2}, 21'h0);
        reset_n = 1'b1;

        // 1: full transfer 4/32/8
        run(50, -1, -1, -1);
        chk("t1_rd_c1", s_ra[1], 32'h100);
        chk("t1_busy_c1", s_bs[1], 1'b1);
        chk("t1_we_c1", {s_wi[1], s_w1[1], s_w2[1]}, 21'h0);
        chk("t1_we_ifm_c2", s_wi[2], 1'b1);
        chk("t1_wa_c2", s_wa[2], 32'h0);
        chk("t1_wd_c2", s_wd[2], gword(32'h100));
        chk("t1_w1_rd_c5", s_ra[5], 32'h200);
        chk("t1_w1_17_we", s_w1[23], 16'h0002);
        chk("t1_w1_17_addr", s_wa[23], 32'd1);
        chk("t1_w1_17_data", s_wd[23], gword(32'h211));
        chk("t1_w2_rd_c37", s_ra[37], 32'h300);
        chk("t1_w2_5_we", s_w2[43], 4'b0010);
        chk("t1_w2_5_addr", s_wa[43], 32'd1);
        chk("t1_w2_7_we", s_w2[45], 4'b1000);
        chk("t1_writes", writes(50), 44);
        chk("t1_multi_we", multi(50), 0);
        chk("t1_done_at", done_at(50), 46);
        chk("t1_busy_c45", s_bs[45], 1'b1);
        chk("t1_busy_c46", s_bs[46], 1'b0);
        chk("t1_done_c47", s_dn[47], 1'b0);

        // 2: empty W1 segment is skipped without a gap
        do_reset();
        set_seg(32'h100, 32'd4, 32'h200, 32'd0, 32'h300, 32'd8);
        run(20, -1, -1, -1);
        chk("t2_ifm_last_c5", s_wi[5], 1'b1);
        chk("t2_w2_rd_c5", s_ra[5], 32'h300);
        chk("t2_w2_first_c6", s_w2[6], 4'b0001);
        chk("t2_w2_addr_c6", s_wa[6], 32'h0);
        chk("t2_w1_never", w1_or(20), 16'h0);
        chk("t2_writes", writes(20), 12);
        chk("t2_done_at", done_at(20), 14);

        // 3: hold during cycles 3-5 in the IFM segment
        do_reset();
        set_seg(32'h100, 32'd4, 32'h200, 32'd32, 32'h300, 32'd8);
        run(52, 3, 5, -1);
        chk("t3_inflight_c3", s_wi[3], 1'b1);
        chk("t3_wa_c3", s_wa[3], 32'd1);
        chk("t3_wa_c4", s_wa[4], 32'd2);
        chk("t3_no_we_c5", {s_wi[5], s_w1[5], s_w2[5]}, 21'h0);
        chk("t3_frozen_c6", s_ra[6], 32'h102);
        chk("t3_resume_c7", s_ra[7], 32'h103);
        chk("t3_we_c8", s_wi[8], 1'b1);
        chk("t3_wa_c8", s_wa[8], 32'd3);
        chk("t3_writes", writes(52), 44);
        chk("t3_done_at", done_at(52), 49);
`ifdef FUSED_LOADER_PERF_EN
        chk("t3_perf_cycles", perf_cycles, 32'd49);
        chk("t3_perf_stall", perf_stall, 32'd3);
`endif

        // 4: all sizes zero
        do_reset();
        set_seg(32'h100, 32'd0, 32'h200, 32'd0, 32'h300, 32'd0);
        run(6, -1, -1, -1);
        chk("t4_busy_c1", s_bs[1], 1'b1);
        chk("t4_done_c1", s_dn[1], 1'b0);
        chk("t4_done_c2", s_dn[2], 1'b1);
        chk("t4_busy_c2", s_bs[2], 1'b0);
        chk("t4_done_c3", s_dn[3], 1'b0);
        chk("t4_rd_c1", s_ra[1], 32'h0);
        chk("t4_writes", writes(6), 0);

        // 5: start re-pulsed mid-W1, then asynchronous reset
        do_reset();
        set_seg(32'h100, 32'd4, 32'h200, 32'd32, 32'h300, 32'd8);
        run(9, -1, -1, 7);
        chk("t5_rd_c8", s_ra[8], 32'h203);
        chk("t5_busy_c8", s_bs[8], 1'b1);
        chk("t5_rd_c9", s_ra[9], 32'h204);
        chk("t5_w1_c9", s_w1[9], 16'h0008);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_rd", rd_addr_global, 32'h0);
        chk("t5_rst_wa", wr_addr_local, 32'h0);
        chk("t5_rst_we", {we_IFM, we_W1, we_W2}, 21'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_idle_after", {busy, done, rd_addr_global}, 34'h0);

        // 6: read address wraps past 2^32
        do_reset();
        set_seg(32'hFFFF_FFFE, 32'd4, 32'h200, 32'd0, 32'h300, 32'd0);
        run(8, -1, -1, -1);
        chk("t6_rd_c1", s_ra[1], 32'hFFFF_FFFE);
        chk("t6_rd_c2", s_ra[2], 32'hFFFF_FFFF);
        chk("t6_rd_c3", s_ra[3], 32'h0000_0000);
        chk("t6_rd_c4", s_ra[4], 32'h0000_0001);
        chk("t6_wd_c4", s_wd[4], gword(32'h0));
        chk("t6_done_at", done_at(8), 6);
`ifdef FUSED_LOADER_PERF_EN
        chk("t6_perf_cycles", perf_cycles, 32'd6);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
